// File: rtl/window_gen3x3_pkg.sv
// Shared sizing for the 3x3 window generator and its downstream conv_layer.
package window_gen3x3_pkg;

    localparam int unsigned DEF_BIT_DEPTH = 16;
    localparam int unsigned DEF_IMG_W     = 28;
    localparam int unsigned DEF_IMG_H     = 28;
    localparam int unsigned KERNEL        = 3;
    localparam int unsigned WIN_PIX       = KERNEL * KERNEL;

endpackage

// File: rtl/window_gen3x3_line_buf.sv
// Enable-gated shift-register delay line; dout is the sample pushed DEPTH accepts ago.
module line_buf #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_gen3x3.sv
// Raster pixel stream to 3x3 sliding windows (stride 1, no padding) for conv_layer.
module window_gen3x3
    import window_gen3x3_pkg::*;
#(
    parameter int unsigned bit_depth = DEF_BIT_DEPTH,
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H
) (
    input  logic                           clk,
    input  logic                           RESET,
    input  logic [bit_depth-1:0]           pix_in,
    input  logic                           pix_valid,
    output logic [WIN_PIX*bit_depth-1:0]   win_data,
    output logic                           win_valid,
    output logic                           frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = WIN_PIX * bit_depth;

    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [bit_depth-1:0] lb0_out;
    logic [bit_depth-1:0] lb1_out;
    logic [bit_depth-1:0] new_col [KERNEL];
    // Two older columns per row; the newest column comes straight from the line buffers.
    logic [bit_depth-1:0] tap [KERNEL][KERNEL-1];
    logic [WIN_W-1:0]     win_c;
    logic                 col_last_c;
    logic                 row_last_c;
    logic                 win_hit_c;

    line_buf #(.DEPTH(IMG_W), .WIDTH(bit_depth)) u_lb1 (
        .clk   (clk),
        .RESET (RESET),
        .en    (pix_valid),
        .din   (pix_in),
        .dout  (lb1_out)
    );

    line_buf #(.DEPTH(IMG_W), .WIDTH(bit_depth)) u_lb0 (
        .clk   (clk),
        .RESET (RESET),
        .en    (pix_valid),
        .din   (lb1_out),
        .dout  (lb0_out)
    );

    always_comb begin
        new_col[0] = lb0_out;
        new_col[1] = lb1_out;
        new_col[2] = pix_in;
    end

    // Assemble {p0..p8} with p0 in the MSBs.
    always_comb begin
        win_c = '0;
        for (int r = 0; r < int'(KERNEL); r++) begin
            win_c[(WIN_PIX - (r*3 + 0))*bit_depth - 1 -: bit_depth] = tap[r][0];
            win_c[(WIN_PIX - (r*3 + 1))*bit_depth - 1 -: bit_depth] = tap[r][1];
            win_c[(WIN_PIX - (r*3 + 2))*bit_depth - 1 -: bit_depth] = new_col[r];
        end
    end

    assign col_last_c = (col == COL_W'(IMG_W - 1));
    assign row_last_c = (row == ROW_W'(IMG_H - 1));
    // col>=2 also hides stale taps left over from the previous row's tail.
    assign win_hit_c  = pix_valid && (col >= COL_W'(2)) && (row >= ROW_W'(2));

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int r = 0; r < int'(KERNEL); r++) begin
                for (int k = 0; k < int'(KERNEL) - 1; k++) tap[r][k] <= '0;
            end
        end else if (pix_valid) begin
            for (int r = 0; r < int'(KERNEL); r++) begin
                tap[r][0] <= tap[r][1];
                tap[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            win_data   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_hit_c;
            frame_done <= pix_valid && col_last_c && row_last_c;
            if (win_hit_c) win_data <= win_c;
        end
    end

endmodule
